irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl_pkg.sv | 22 ++
 rtl/irq_prio.sv | 20 ++
 rtl/irq_ctrl.sv | 133 +++++++++++++
 tb/tb_irq_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl shared types and constants.
// FSM encoding, default vector base, source-count bound.
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;

  localparam logic [15:0] VEC_BASE_DEF = 16'hFFF0;
  localparam int          NSRC_MAX     = 8;

  // Vector slots are two bytes apart; wraps in 16 bits.
  function automatic logic [15:0] vec_of(
    input logic [15:0] base,
    input logic [2:0]  idx
  );
    return base + {12'd0, idx, 1'b0};
  endfunction

endpackage

// File: rtl/irq_prio.sv
// Lowest-index-wins priority encoder.
// Combinational; idx is 0 when no request is present.
module irq_prio #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic         any,
  output logic [2:0]   idx
);

  // Scan high to low so the lowest set bit is written last.
  always_comb begin
    any = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Prioritised interrupt controller, IDLE/REQ/SERV handshake.
// Optional mask register: define IRQ_MASK_EN.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int              NSRC      = 4,
  parameter logic [NSRC-1:0] EDGE_MASK = '1,
  parameter logic [15:0]     VEC_BASE  = VEC_BASE_DEF
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            ce,
  input  logic [NSRC-1:0] src,
  input  logic            iflag,
  input  logic            ack,
  input  logic            eoi,
  input  logic            we,
  input  logic [NSRC-1:0] wd,
  output logic            irq,
  output logic [2:0]      id,
  output logic [15:0]     vec,
  output logic            active
);

  state_t          state, state_n;
  logic [2:0]      id_n;
  logic            armed;
  logic [NSRC-1:0] src_d;
  logic [NSRC-1:0] pend_e, pend_e_n;
  logic [NSRC-1:0] rise, clr;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] en, blk, elig;
  logic            any;
  logic [2:0]      sel;

`ifdef IRQ_MASK_EN
  logic [NSRC-1:0] mask;

  // Mask register; bit 0 is forced on below (NMI).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mask <= '1;
    end else if (ce && we) begin
      mask <= wd;
    end
  end

  assign en = mask | NSRC'(1);
`else
  logic unused_cfg;

  assign en         = '1;
  assign unused_cfg = ^{we, wd};
`endif

  // Edge detect; the first ce edge after reset only
  // primes src_d so a level held through reset is not an edge.
  assign rise = src & ~src_d & EDGE_MASK
              & {NSRC{armed}};

  assign pending = (pend_e & EDGE_MASK)
                 | (src & ~EDGE_MASK);

  // The I flag blocks everything except source 0.
  always_comb begin
    blk = '1;
    if (iflag) blk = NSRC'(1);
  end

  assign elig = pending & en & blk;

  irq_prio #(
    .N (NSRC)
  ) u_prio (
    .req (elig),
    .any (any),
    .idx (sel)
  );

  // Next state, id re-selection and ack clear.
  always_comb begin
    state_n = state;
    id_n    = id;
    clr     = '0;
    unique case (state)
      IDLE: begin
        if (any) begin
          state_n = REQ;
          id_n    = sel;
        end
      end
      REQ: begin
        if (ack) begin
          state_n = SERV;
          clr     = NSRC'(1) << id;
        end else if (any) begin
          id_n = sel;
        end else begin
          state_n = IDLE;
        end
      end
      SERV: begin
        if (eoi) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // A fresh edge beats the ack clear on the same cycle.
  assign pend_e_n = (pend_e & ~clr) | rise;

  // State and capture registers, advanced on ce only.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      id     <= '0;
      armed  <= 1'b0;
      src_d  <= '0;
      pend_e <= '0;
    end else if (ce) begin
      state  <= state_n;
      id     <= id_n;
      armed  <= 1'b1;
      src_d  <= src;
      pend_e <= pend_e_n;
    end
  end

  assign irq    = (state == REQ);
  assign active = (state == SERV);
  assign vec    = vec_of(VEC_BASE, id);

endmodule

// File: tb/tb_irq_ctrl.sv
// Testbench for irq_ctrl: vector table plus corner sequences.
// Checks an all-edge instance and a level-src0 instance.
module tb_irq_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b0;
  logic [3:0]  src = '0;
  logic        iflag = 1'b0;
  logic        ack = 1'b0;
  logic        eoi = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  wd = '0;

  logic        irq, active;
  logic [2:0]  id;
  logic [15:0] vec;
  logic        irq_l, active_l;
  logic [2:0]  id_l;
  logic [15:0] vec_l;

  int checks = 0;
  int failures = 0;

  irq_ctrl #(
    .NSRC      (4),
    .EDGE_MASK (4'b1111),
    .VEC_BASE  (16'hFFF0)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .ce      (ce),
    .src     (src),
    .iflag   (iflag),
    .ack     (ack),
    .eoi     (eoi),
    .we      (we),
    .wd      (wd),
    .irq     (irq),
    .id      (id),
    .vec     (vec),
    .active  (active)
  );

  irq_ctrl #(
    .NSRC      (4),
    .EDGE_MASK (4'b1110),
    .VEC_BASE  (16'hFFF0)
  ) dut_l (
    .clock   (clock),
    .reset_n (reset_n),
    .ce      (ce),
    .src     (src),
    .iflag   (iflag),
    .ack     (ack),
    .eoi     (eoi),
    .we      (we),
    .wd      (wd),
    .irq     (irq_l),
    .id      (id_l),
    .vec     (vec_l),
    .active  (active_l)
  );

  always #20 clock = ~clock;

  typedef struct {
    bit         ce;
    logic [3:0] src;
    bit         iflag;
    bit         ack;
    bit         eoi;
    bit         we;
    logic [3:0] wd;
    bit         irq;
    logic [2:0] id;
    bit         act;
  } vec_t;

  typedef struct {
    bit          irq;
    logic [2:0]  id;
    bit          act;
    logic [15:0] vec;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];

  function automatic vec_t mk(
    bit c, logic [3:0] s, bit fl, bit a, bit e,
    bit r, int i, bit t
  );
    vec_t v;
    v.ce = c; v.src = s; v.iflag = fl;
    v.ack = a; v.eoi = e;
    v.we = 1'b0; v.wd = '0;
    v.irq = r; v.id = 3'(i); v.act = t;
    return v;
  endfunction

  function automatic vec_t mkw(
    logic [3:0] s, logic [3:0] d,
    bit r, int i, bit t
  );
    vec_t v;
    v = mk(1'b1, s, 1'b0, 1'b0, 1'b0, r, i, t);
    v.we = 1'b1; v.wd = d;
    return v;
  endfunction

  function automatic exp_t mkexp(
    bit r, logic [2:0] i, bit t
  );
    exp_t e;
    e.irq = r; e.id = i; e.act = t;
    e.vec = 16'hFFF0 + {12'd0, i, 1'b0};
    return e;
  endfunction

  task automatic chk(
    string nm, logic g_irq, logic [2:0] g_id,
    logic g_act, logic [15:0] g_vec, exp_t e
  );
    checks++;
    if ({g_irq, g_id, g_act, g_vec} !==
        {e.irq, e.id, e.act, e.vec}) begin
      failures++;
      $display("FAIL %s got irq=%0b id=%0d active=%0b vec=%h want irq=%0b id=%0d active=%0b vec=%h",
               nm, g_irq, g_id, g_act, g_vec,
               e.irq, e.id, e.act, e.vec);
    end
  endtask

  task automatic cyc(string nm, vec_t v, bit lvl);
    exp_t e;
    @(negedge clock);
    ce = v.ce; src = v.src; iflag = v.iflag;
    ack = v.ack; eoi = v.eoi;
    we = v.we; wd = v.wd;
    exp_q.push_back(mkexp(v.irq, v.id, v.act));
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty", nm);
    end else begin
      e = exp_q.pop_front();
      if (lvl)
        chk(nm, irq_l, id_l, active_l, vec_l, e);
      else
        chk(nm, irq, id, active, vec, e);
    end
  endtask

  task automatic do_reset(string nm);
    @(negedge clock);
    reset_n = 1'b0;
    ce = 1'b0; src = '0; iflag = 1'b0;
    ack = 1'b0; eoi = 1'b0; we = 1'b0; wd = '0;
    @(posedge clock);
    #1;
    chk({nm, "_rst"}, irq, id, active, vec,
        mkexp(1'b0, 3'd0, 1'b0));
    chk({nm, "_rst_l"}, irq_l, id_l, active_l, vec_l,
        mkexp(1'b0, 3'd0, 1'b0));
    @(negedge clock);
    reset_n = 1'b1;
    cyc({nm, "_arm"}, mk(1,4'b0000,0,0,0, 0,0,0), 1'b0);
  endtask

  initial begin
    // A: single edge source, latency, ack, eoi
    tbl.push_back(mk(1,4'b0000,0,0,0, 0,0,0));
    tbl.push_back(mk(1,4'b0100,0,0,0, 0,0,0));
    tbl.push_back(mk(1,4'b0100,0,0,0, 1,2,0));
    tbl.push_back(mk(1,4'b0100,0,0,0, 1,2,0));
    tbl.push_back(mk(1,4'b0100,0,1,0, 0,2,1));
    tbl.push_back(mk(1,4'b0000,0,0,0, 0,2,1));
    tbl.push_back(mk(1,4'b0000,0,0,1, 0,2,0));
    tbl.push_back(mk(1,4'b0000,0,0,0, 0,2,0));
    // B: supersede before ack, then re-serve 3
    tbl.push_back(mk(1,4'b1000,0,0,0, 0,2,0));
    tbl.push_back(mk(1,4'b1000,0,0,0, 1,3,0));
    tbl.push_back(mk(1,4'b1010,0,0,0, 1,3,0));
    tbl.push_back(mk(1,4'b1010,0,0,0, 1,1,0));
    tbl.push_back(mk(1,4'b1010,0,1,0, 0,1,1));
    tbl.push_back(mk(1,4'b0000,0,0,1, 0,1,0));
    tbl.push_back(mk(1,4'b0000,0,0,0, 1,3,0));
    tbl.push_back(mk(1,4'b0000,0,1,0, 0,3,1));
    tbl.push_back(mk(1,4'b0000,0,0,1, 0,3,0));
    // C: I flag blocks all but source 0
    tbl.push_back(mk(1,4'b0011,1,0,0, 0,3,0));
    tbl.push_back(mk(1,4'b0011,1,0,0, 1,0,0));
    tbl.push_back(mk(1,4'b0011,1,1,0, 0,0,1));
    tbl.push_back(mk(1,4'b0011,1,0,1, 0,0,0));
    tbl.push_back(mk(1,4'b0011,1,0,0, 0,0,0));
    tbl.push_back(mk(1,4'b0000,1,0,0, 0,0,0));
    tbl.push_back(mk(1,4'b0000,0,0,0, 1,1,0));
    tbl.push_back(mk(1,4'b0000,0,1,0, 0,1,1));
    tbl.push_back(mk(1,4'b0000,0,0,1, 0,1,0));
    // D: withdraw, ack vs new edge, NMI in SERV
    tbl.push_back(mk(1,4'b0100,0,0,0, 0,1,0));
    tbl.push_back(mk(1,4'b0100,0,0,0, 1,2,0));
    tbl.push_back(mk(1,4'b0100,1,0,0, 0,2,0));
    tbl.push_back(mk(1,4'b0100,1,0,0, 0,2,0));
    tbl.push_back(mk(1,4'b0100,0,0,0, 1,2,0));
    tbl.push_back(mk(1,4'b0000,0,0,0, 1,2,0));
    tbl.push_back(mk(1,4'b0100,0,1,0, 0,2,1));
    tbl.push_back(mk(1,4'b0100,0,0,1, 0,2,0));
    tbl.push_back(mk(1,4'b0100,0,0,0, 1,2,0));
    tbl.push_back(mk(1,4'b0100,0,1,0, 0,2,1));
    tbl.push_back(mk(1,4'b0101,0,0,0, 0,2,1));
    tbl.push_back(mk(1,4'b0101,0,1,0, 0,2,1));
    tbl.push_back(mk(1,4'b0101,0,0,1, 0,2,0));
    tbl.push_back(mk(1,4'b0101,0,0,0, 1,0,0));
    tbl.push_back(mk(1,4'b0101,0,0,1, 1,0,0));
    tbl.push_back(mk(1,4'b0101,0,1,0, 0,0,1));
    tbl.push_back(mk(1,4'b0000,0,0,1, 0,0,0));
    // E: ce low freezes everything
    tbl.push_back(mk(0,4'b0010,0,0,0, 0,0,0));
    tbl.push_back(mk(0,4'b0000,0,0,0, 0,0,0));
    tbl.push_back(mk(0,4'b1000,0,0,0, 0,0,0));
    tbl.push_back(mk(0,4'b1000,0,1,0, 0,0,0));
    tbl.push_back(mk(0,4'b0000,0,0,0, 0,0,0));
    tbl.push_back(mk(1,4'b0000,0,0,0, 0,0,0));
    tbl.push_back(mk(1,4'b0000,0,0,0, 0,0,0));
    tbl.push_back(mk(1,4'b0010,0,0,0, 0,0,0));
    tbl.push_back(mk(0,4'b0010,0,0,0, 0,0,0));
    tbl.push_back(mk(1,4'b0010,0,0,0, 1,1,0));
    tbl.push_back(mk(0,4'b0010,0,1,0, 1,1,0));
    tbl.push_back(mk(1,4'b0010,0,1,0, 0,1,1));
    tbl.push_back(mk(1,4'b0000,0,0,1, 0,1,0));

    do_reset("init");

    for (int k = 0; k < tbl.size(); k++) begin
      cyc($sformatf("tbl[%0d]", k), tbl[k], 1'b0);
    end

    // Level source 0 pulsing during SERV leaves nothing
    do_reset("lvl");
    cyc("lvl1",  mk(1,4'b0010,0,0,0, 0,0,0), 1'b1);
    cyc("lvl2",  mk(1,4'b0010,0,0,0, 1,1,0), 1'b1);
    cyc("lvl3",  mk(1,4'b0010,0,1,0, 0,1,1), 1'b1);
    cyc("lvl4",  mk(1,4'b0011,0,0,0, 0,1,1), 1'b1);
    cyc("lvl5",  mk(1,4'b0010,0,0,0, 0,1,1), 1'b1);
    cyc("lvl6",  mk(1,4'b0000,0,0,1, 0,1,0), 1'b1);
    cyc("lvl7",  mk(1,4'b0000,0,0,0, 0,1,0), 1'b1);
    cyc("lvl8",  mk(1,4'b0000,0,0,0, 0,1,0), 1'b1);
    cyc("lvl9",  mk(1,4'b0001,0,0,0, 1,0,0), 1'b1);
    cyc("lvl10", mk(1,4'b0000,0,0,0, 0,0,0), 1'b1);

    // Async reset mid-SERV with a request pending
    do_reset("rsv");
    cyc("rsv1", mk(1,4'b0100,0,0,0, 0,0,0), 1'b0);
    cyc("rsv2", mk(1,4'b0100,0,0,0, 1,2,0), 1'b0);
    cyc("rsv3", mk(1,4'b0100,0,1,0, 0,2,1), 1'b0);
    cyc("rsv4", mk(1,4'b1100,0,0,0, 0,2,1), 1'b0);
    @(negedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    chk("rsv_async", irq, id, active, vec,
        mkexp(1'b0, 3'd0, 1'b0));
    @(negedge clock);
    reset_n = 1'b1;
    cyc("rsv5", mk(1,4'b1100,0,0,0, 0,0,0), 1'b0);
    cyc("rsv6", mk(1,4'b1100,0,0,0, 0,0,0), 1'b0);
    cyc("rsv7", mk(1,4'b1100,0,0,0, 0,0,0), 1'b0);

`ifdef IRQ_MASK_EN
    do_reset("msk");
    cyc("msk1", mkw(4'b0000, 4'b0001, 0,0,0), 1'b0);
    cyc("msk2", mk(1,4'b0100,0,0,0, 0,0,0), 1'b0);
    cyc("msk3", mk(1,4'b0100,0,0,0, 0,0,0), 1'b0);
    cyc("msk4", mkw(4'b0100, 4'b0101, 0,0,0), 1'b0);
    cyc("msk5", mk(1,4'b0100,0,0,0, 1,2,0), 1'b0);
    cyc("msk6", mk(1,4'b0100,0,1,0, 0,2,1), 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
